// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard interface: hazard inputs from the datapath plus stall/flush controls back to it.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1_label_i;
  logic [4:0]       id_rs2_label_i;
  logic             id_uses_rs1_i;
  logic             id_uses_rs2_i;
  logic [4:0]       ex_rd_i;
  logic             ex_is_load_i;
  logic             ex_reg_wb_en_i;
  logic             ex_branch_taken_i;
  logic             imem_busywait_i;
  logic             dmem_busywait_i;
  logic             clr_cnt_i;
  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_busywait_o;
  logic             id_ex_flush_o;
  logic             back_busywait_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_count_o;

  // Datapath side: drives hazard information, consumes controls
  modport master (
    output id_rs1_label_i, id_rs2_label_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_rd_i, ex_is_load_i, ex_reg_wb_en_i, ex_branch_taken_i,
           imem_busywait_i, dmem_busywait_i, clr_cnt_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_busywait_o,
           id_ex_flush_o, back_busywait_o, state_o, stall_count_o
  );

  // Controller side
  modport slave (
    input  id_rs1_label_i, id_rs2_label_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_rd_i, ex_is_load_i, ex_reg_wb_en_i, ex_branch_taken_i,
           imem_busywait_i, dmem_busywait_i, clr_cnt_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_busywait_o,
           id_ex_flush_o, back_busywait_o, state_o, stall_count_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, taken-branch
// squashes and memory wait states. Controls are Mealy outputs of state and inputs.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_BUBBLE     = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_FLUSH_PEND = 2'd3
  } state_t;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_bub;
  logic [1:0]       w_bub_next;
  logic [CNT_W-1:0] r_cnt;

  logic w_busy;
  logic w_br;
  logic w_lu;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_bw;
  logic w_id_ex_flush;
  logic w_back_bw;

  assign w_busy = bus.imem_busywait_i | bus.dmem_busywait_i;
  assign w_br   = bus.ex_branch_taken_i;
  assign w_lu   = bus.ex_is_load_i & bus.ex_reg_wb_en_i & (bus.ex_rd_i != 5'd0) &
                  ((bus.id_uses_rs1_i & (bus.id_rs1_label_i == bus.ex_rd_i)) |
                   (bus.id_uses_rs2_i & (bus.id_rs2_label_i == bus.ex_rd_i)));

  // State and bubble counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
      r_bub   <= '0;
    end else begin
      r_state <= w_state_next;
      r_bub   <= w_bub_next;
    end
  end

  // Next-state: MEM_WAIT shares the RUN decision once memory is ready, so there is no dead cycle
  always_comb begin
    w_state_next = r_state;
    w_bub_next   = r_bub;
    unique case (r_state)
      S_RUN, S_MEM_WAIT: begin
        if (w_busy) begin
          w_state_next = w_br ? S_FLUSH_PEND : S_MEM_WAIT;
        end else if (w_br) begin
          w_state_next = S_RUN;
        end else if (w_lu && (LOAD_USE_BUBBLES > 1)) begin
          w_state_next = S_BUBBLE;
          w_bub_next   = BUB_INIT;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_BUBBLE: begin
        if (!w_busy) begin
          if (w_br) begin
            w_state_next = S_RUN;
            w_bub_next   = '0;
          end else begin
            w_bub_next = r_bub - 2'd1;
            if (r_bub == 2'd1) w_state_next = S_RUN;
          end
        end
      end
      S_FLUSH_PEND: begin
        if (!w_busy) w_state_next = S_RUN;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  // Control outputs: reset squashes both front registers; busy freezes everything
  always_comb begin
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_bw    = 1'b0;
    w_id_ex_flush = 1'b0;
    w_back_bw     = 1'b0;
    if (rst_i) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_busy) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_bw    = 1'b1;
      w_back_bw     = 1'b1;
    end else if ((r_state == S_FLUSH_PEND) || w_br) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if ((r_state == S_BUBBLE) || w_lu) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end
  end

  // Saturating count of PC-stall cycles; clear wins over increment
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clr_cnt_i) begin
      r_cnt <= '0;
    end else if (w_pc_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.pc_stall_o       = w_pc_stall;
  assign bus.if_id_stall_o    = w_if_id_stall;
  assign bus.if_id_flush_o    = w_if_id_flush;
  assign bus.id_ex_busywait_o = w_id_ex_bw;
  assign bus.id_ex_flush_o    = w_id_ex_flush;
  assign bus.back_busywait_o  = w_back_bw;
  assign bus.state_o          = r_state;
  assign bus.stall_count_o    = r_cnt;

endmodule
